// File: rtl/rvc_asap_muldiv.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, one op in flight.
module rvc_asap_muldiv #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [4:0]      req_rd_i,
  input  logic            kill_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_result_o,
  output logic [4:0]      rsp_rd_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  localparam logic [XLEN-1:0]  MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   b_q;
  logic [2:0]        op_q;
  logic [4:0]        tag_q;
  logic              neg_q, rem_neg_q;
  logic              req_ready_q, rsp_valid_q, busy_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;

  logic              sign_a, sign_b, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;
  logic [2*XLEN-1:0] mul_sum, prod_s, div_nx;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res;

  // Accept-time decode: operand signs, magnitudes and the no-iteration divide cases.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    if (req_op_i[2]) begin
      sign_a = ~req_op_i[0] & req_rs1_i[XLEN-1];
      sign_b = ~req_op_i[0] & req_rs2_i[XLEN-1];
    end else begin
      sign_a = (req_op_i[1:0] == 2'b01 || req_op_i[1:0] == 2'b10) & req_rs1_i[XLEN-1];
      sign_b = (req_op_i[1:0] == 2'b01) & req_rs2_i[XLEN-1];
    end
    mag_a = sign_a ? -req_rs1_i : req_rs1_i;
    mag_b = sign_b ? -req_rs2_i : req_rs2_i;
    special_res = '0;
    special = 1'b0;
    if (req_op_i[2] && req_rs2_i == '0) begin
      special = 1'b1;
      special_res = req_op_i[1] ? req_rs1_i : '1;
    end else if (req_op_i[2] && !req_op_i[0] && req_rs1_i == MIN_INT && req_rs2_i == '1) begin
      special = 1'b1;
      special_res = req_op_i[1] ? '0 : req_rs1_i;
    end
  end

  // One iteration of each datapath, plus the sign-corrected result used on the last one.
  always_comb begin
    mul_sum = acc_q + (b_q[0] ? mcand_q : '0);
    trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    div_nx  = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                          : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod_s  = neg_q ? -mul_sum : mul_sum;
    mul_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo     = div_nx[XLEN-1:0];
    rem     = div_nx[2*XLEN-1:XLEN];
    div_res = op_q[1] ? (rem_neg_q ? -rem : rem) : (neg_q ? -quo : quo);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
    end else if (kill_i && state_q != IDLE) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_q && !kill_i) begin
            op_q        <= req_op_i;
            tag_q       <= req_rd_i;
            neg_q       <= sign_a ^ sign_b;
            rem_neg_q   <= sign_a;
            b_q         <= mag_b;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (special) begin
              result_q    <= special_res;
              rd_q        <= req_rd_i;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (req_op_i[2]) begin
              acc_q   <= {{XLEN{1'b0}}, mag_a};
              state_q <= DIV;
            end else begin
              acc_q   <= '0;
              mcand_q <= {{XLEN{1'b0}}, mag_a};
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          acc_q   <= mul_sum;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            result_q    <= mul_res;
            rd_q        <= tag_q;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DIV: begin
          acc_q <= div_nx;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            result_q    <= div_res;
            rd_q        <= tag_q;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_rd_o     = rd_q;
  assign busy_o       = busy_q;

endmodule
